// File: rtl/mux_bin_pipe.sv
// mux_bin_pipe: pipelined radix-SPLIT binary-select mux tree with valid/ready flow control.
// Define MUX_BIN_PIPE_RANGE_CHECK_EN to flag (err) results whose bin >= WIDTH.
module mux_bin_pipe #(
   parameter type         DAT_T = logic [8-1:0],
   parameter int          WIDTH = 32,
   parameter int          SPLIT = 2,
   parameter logic [31:0] REG   = '1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [$clog2(WIDTH)-1:0] bin,
   input  DAT_T [WIDTH-1:0]         ary,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output DAT_T                     dat,
   output logic                     err
);

   localparam int WIDTH_LOG = $clog2(WIDTH);
   localparam int SPLIT_LOG = (SPLIT < 2) ? 1 : $clog2(SPLIT);
   localparam int LEVELS    = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
   localparam int POWER     = SPLIT ** LEVELS;
   localparam int BIN_W     = LEVELS * SPLIT_LOG;

   // Entry offset of the array entering level k inside the flattened tree vector.
   function automatic int dofs(input int k);
      int s;
      int n;
      s = 0;
      n = POWER;
      for (int i = 0; i < k; i++) begin
         s += n;
         n /= SPLIT;
      end
      return s;
   endfunction

   function automatic int bofs(input int k);
      int s;
      s = 0;
      for (int i = 0; i < k; i++) s += (LEVELS - i) * SPLIT_LOG;
      return s;
   endfunction

   localparam int D_TOT = dofs(LEVELS) + 1;
   localparam int B_TOT = bofs(LEVELS);

   if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
      $error("mux_bin_pipe: SPLIT must be a power of 2 and >= 2");
   end

   wire DAT_T [D_TOT-1:0] lv;
   wire logic [B_TOT-1:0] bs;
   wire logic [LEVELS:0]  vs;
   wire logic [LEVELS:0]  rs;

   assign lv[0 +: WIDTH] = ary;
   if (POWER > WIDTH) begin : g_pad
      assign lv[WIDTH +: POWER-WIDTH] = '0;
   end

   assign bs[0 +: BIN_W] = BIN_W'(bin);
   assign vs[0]          = in_vld;
   assign in_rdy         = rs[0];
   assign out_vld        = vs[LEVELS];
   assign rs[LEVELS]     = out_rdy;
   assign dat            = lv[D_TOT-1];

`ifdef MUX_BIN_PIPE_RANGE_CHECK_EN
   wire logic [LEVELS:0] es;
   // Out-of-range selects land on zero pad entries, so only the flag needs carrying.
   assign es[0] = (32'(bin) >= WIDTH);
   assign err   = es[LEVELS];
`else
   assign err = 1'b0;
`endif

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int NO    = POWER / (SPLIT ** (k + 1));
      localparam int D_IN  = dofs(k);
      localparam int D_OUT = dofs(k + 1);
      localparam int B_IN  = bofs(k);
      localparam int B_OUT = bofs(k + 1);
      localparam int BN    = (LEVELS - k - 1) * SPLIT_LOG;

      logic [SPLIT_LOG-1:0] sel;
      DAT_T [NO-1:0]        d_c;

      assign sel = bs[B_IN +: SPLIT_LOG];

      always_comb begin
         d_c = '0;
         for (int j = 0; j < NO; j++) begin
            for (int s = 0; s < SPLIT; s++) begin
               if (sel == SPLIT_LOG'(s)) d_c[j] = lv[D_IN + j*SPLIT + s];
            end
         end
      end

      if (REG[k]) begin : g_reg
         logic          v_q;
         logic          ld;
         DAT_T [NO-1:0] d_q;

         assign ld = vs[k] && rs[k];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               d_q <= '0;
            end else begin
               if (rs[k]) v_q <= vs[k];
               if (ld)    d_q <= d_c;
            end
         end

         assign rs[k]            = !v_q || rs[k+1];
         assign vs[k+1]          = v_q;
         assign lv[D_OUT +: NO]  = d_q;

         if (BN > 0) begin : g_bin
            logic [BN-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)  b_q <= '0;
               else if (ld) b_q <= bs[B_IN+SPLIT_LOG +: BN];
            end
            assign bs[B_OUT +: BN] = b_q;
         end

`ifdef MUX_BIN_PIPE_RANGE_CHECK_EN
         logic e_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  e_q <= 1'b0;
            else if (ld) e_q <= es[k];
         end
         assign es[k+1] = e_q;
`endif
      end else begin : g_comb
         assign rs[k]           = rs[k+1];
         assign vs[k+1]         = vs[k];
         assign lv[D_OUT +: NO] = d_c;

         if (BN > 0) begin : g_bin
            assign bs[B_OUT +: BN] = bs[B_IN+SPLIT_LOG +: BN];
         end

`ifdef MUX_BIN_PIPE_RANGE_CHECK_EN
         assign es[k+1] = es[k];
`endif
      end
   end

endmodule
